// File: rtl/mem_responder.sv
// Word-array memory responder: a single outstanding request, a fixed number of access wait
// states, and a response held until the CPU accepts it.
// Optional build macro: MEM_RESPONDER_ALIGN_CHECK_EN (a misaligned byte address is an error).
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BEW   = DW / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [BEW-1:0]     be_q, be_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic [DW-1:0]      mem_q [DEPTH];

    logic               op_write_c;
    logic [AW-1:0]      op_addr_c;
    logic [DW-1:0]      op_wdata_c;
    logic [BEW-1:0]     op_be_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic               out_of_range_c;
    logic               misalign_c;
    logic               err_c;
    logic               enter_resp_c;
    logic               mem_we_c;

    // With zero wait states the access completes on the accepting edge, so use the live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            op_write_c = req_write;
            op_addr_c  = req_addr;
            op_wdata_c = req_wdata;
            op_be_c    = req_be;
        end else begin
            op_write_c = write_q;
            op_addr_c  = addr_q;
            op_wdata_c = wdata_q;
            op_be_c    = be_q;
        end
    end

    assign idx_c          = op_addr_c[DEPTH_LOG2+1:2];
    assign out_of_range_c = (op_addr_c >> (DEPTH_LOG2 + 2)) != '0;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign misalign_c = |op_addr_c[1:0];
`else
    logic [1:0] unused_addr_lsb_c;
    assign misalign_c        = 1'b0;
    assign unused_addr_lsb_c = op_addr_c[1:0];
`endif

    assign err_c    = out_of_range_c | misalign_c;
    assign mem_we_c = enter_resp_c & op_write_c & ~err_c & ~reset;

    // Next-state and response datapath
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        enter_resp_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_STATES == 0) begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d      = RESP;
                    cnt_d        = '0;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp_c) begin
            err_d   = err_c;
            rdata_d = (!err_c && !op_write_c) ? mem_q[idx_c] : '0;
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Array is deliberately not reset; byte lanes commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < BEW; b++) begin
                if (op_be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= op_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with zero wait states.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset, reset0;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    bit          use0 = 1'b0;
    logic        ready_m, valid_m, err_m;
    logic [31:0] rdata_m;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset0),
        .req_valid(req_valid), .req_ready(req_ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    assign ready_m = use0 ? req_ready0  : req_ready1;
    assign valid_m = use0 ? resp_valid0 : resp_valid1;
    assign err_m   = use0 ? resp_err0   : resp_err1;
    assign rdata_m = use0 ? resp_rdata0 : resp_rdata1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: accept, measure latency, check response, handshake.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        int lat;
        n = 0;
        while (!ready_m && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(ready_m), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        step();
        req_valid = 1'b0;
        req_wdata = 32'h5A5A_5A5A;
        req_addr  = 32'hFFFF_FFFF;
        lat = 1;
        while (!valid_m && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rdata_m, exp_rdata);
        check({tag, "_err"}, 32'(err_m), 32'(exp_err));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_clr"}, {valid_m, err_m, 30'd0} | rdata_m, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        reset0     = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b0;
        step();
        step();
        check("rst_ready", 32'(req_ready1), 32'd1);
        check("rst_valid", 32'(resp_valid1), 32'd0);
        check("rst_rdata", resp_rdata1, 32'd0);
        check("rst_err", 32'(resp_err1), 32'd0);
        reset = 1'b0;
        step();

        // Full write, full read, byte-lane merge
        do_req("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3, 32'd0, 1'b0);
        do_req("rd10", 1'b0, 32'h10, 32'd0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0);
        do_req("wr10b", 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 3, 32'd0, 1'b0);
        do_req("rd10b", 1'b0, 32'h10, 32'd0, 4'h0, 3, 32'hDEAD_BEAA, 1'b0);
        do_req("wr10z", 1'b1, 32'h10, 32'h1111_1111, 4'h0, 3, 32'd0, 1'b0);
        do_req("rd10z", 1'b0, 32'h10, 32'd0, 4'h0, 3, 32'hDEAD_BEAA, 1'b0);

        // Out of range: 0x400 aliases word 0 in its index bits but must not touch it
        do_req("wr00", 1'b1, 32'h0, 32'h1122_3344, 4'hF, 3, 32'd0, 1'b0);
        do_req("rd400", 1'b0, 32'h400, 32'd0, 4'h0, 3, 32'd0, 1'b1);
        do_req("wr400", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 3, 32'd0, 1'b1);
        do_req("rd00", 1'b0, 32'h0, 32'd0, 4'h0, 3, 32'h1122_3344, 1'b0);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        do_req("rd13", 1'b0, 32'h13, 32'd0, 4'h0, 3, 32'd0, 1'b1);
`else
        do_req("rd13", 1'b0, 32'h13, 32'd0, 4'h0, 3, 32'hDEAD_BEAA, 1'b0);
`endif

        // Back-pressure with a pending request
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        step();
        req_addr  = 32'h0;
        step();
        step();
        check("bp_first", 32'(resp_valid1), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(resp_valid1), 32'd1);
            check("bp_rdata", resp_rdata1, 32'hDEAD_BEAA);
            check("bp_ready", 32'(req_ready1), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_idle_ready", 32'(req_ready1), 32'd1);
        check("bp_idle_valid", 32'(resp_valid1), 32'd0);
        step();
        req_valid = 1'b0;
        check("bp_accepted", 32'(req_ready1), 32'd0);
        step();
        step();
        check("bp2_valid", 32'(resp_valid1), 32'd1);
        check("bp2_rdata", resp_rdata1, 32'h1122_3344);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Idle with no request does nothing
        step();
        step();
        check("idle_ready", 32'(req_ready1), 32'd1);
        check("idle_valid", 32'(resp_valid1), 32'd0);

        // Reset in the middle of ACCESS abandons the write
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready1), 32'd1);
        check("mid_rst_valid", 32'(resp_valid1), 32'd0);
        check("mid_rst_rdata", resp_rdata1, 32'd0);
        check("mid_rst_err", 32'(resp_err1), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("rd20_valid", 32'(resp_valid1), 32'd1);
        check("rd20_not_committed", 32'(resp_rdata1 !== 32'h1234_5678), 32'd1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Zero-wait-state instance
        reset = 1'b1;
        use0  = 1'b1;
        step();
        reset0 = 1'b0;
        step();
        do_req("z_wr08", 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 1, 32'd0, 1'b0);
        do_req("z_rd08", 1'b0, 32'h8, 32'd0, 4'h0, 1, 32'hCAFE_F00D, 1'b0);
        do_req("z_rd400", 1'b0, 32'h400, 32'd0, 4'h0, 1, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: word-array depth is 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_STATES, default 2: access-phase cycles per request, legal range 0..15.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder able to accept a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address from the CPU memory address register.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  write byte enables; bit n covers bits [8n+7:8n].
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  read data; 0 for writes and errored accesses.
REQ-014 resp_err  output  1  access error flag, valid while resp_valid=1.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 Request accepted on a posedge with req_valid=1 and req_ready=1; req_write, req_addr, req_wdata and req_be are captured into internal registers on that edge and later input changes are ignored.
REQ-017 IDLE->ACCESS on acceptance when WAIT_STATES>0; IDLE->RESP on acceptance when WAIT_STATES=0.
REQ-018 ACCESS lasts exactly WAIT_STATES cycles, tracked by a 4-bit down-counter; ACCESS->RESP when the counter reaches 1.
REQ-019 Acceptance-to-resp_valid latency is WAIT_STATES+1 cycles.
REQ-020 Word index is captured addr[DEPTH_LOG2+1:2]; out of range when captured addr[31:DEPTH_LOG2+2] != 0.
REQ-021 In-range write commits the bytes enabled by req_be to the array on the edge entering RESP; disabled bytes are unchanged; req_be=0 is a legal no-op write with resp_err=0.
REQ-022 In-range read loads resp_rdata from the array on the edge entering RESP, reflecting all previously committed writes.
REQ-023 Out-of-range access: no array update, resp_rdata=0, resp_err=1.
REQ-024 resp_rdata and resp_err are stable throughout RESP; RESP->IDLE on a posedge with resp_ready=1, clearing resp_rdata and resp_err to 0.
REQ-025 resp_ready=1 in the first RESP cycle gives a one-cycle response; resp_ready held 0 keeps RESP indefinitely.
REQ-026 No overlap: a req_valid asserted during ACCESS or RESP waits; earliest acceptance is the cycle after the return to IDLE.
REQ-027 req_valid deasserted in IDLE leaves the FSM in IDLE with no side effects.

Reset
REQ-028 While reset=1: state IDLE, counter 0, captured-request registers 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 Array contents are not reset; a read of a never-written word returns an undefined value.
REQ-030 Reset during ACCESS abandons the request with no array commit; reset during RESP drops the response.

Configuration
REQ-031 Macro MEM_RESPONDER_ALIGN_CHECK_EN defined: captured addr[1:0] != 0 is an error, handled as REQ-023 with no array update, resp_rdata=0, resp_err=1.
REQ-032 Macro MEM_RESPONDER_ALIGN_CHECK_EN undefined: addr[1:0] is ignored, and misaligned addresses access the containing word.

Verification
REQ-033 WAIT_STATES=2: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> resp_valid exactly 3 cycles after each acceptance; read returns rdata=0xDEADBEEF, err=0.
REQ-034 After the REQ-033 write, write 0x000000AA to 0x10 with be=0x1, then read -> rdata=0xDEADBEAA.
REQ-035 DEPTH_LOG2=8: read 0x400 -> rdata=0, err=1; write 0x400 -> err=1, and the array is unchanged (word 0 still reads its prior value).
REQ-036 Hold resp_ready=0 for 5 cycles with a new req_valid pending -> resp_valid and rdata stay stable, req_ready=0; the new request is accepted the cycle after the resp_ready handshake.
REQ-037 Assert reset mid-ACCESS of a write of 0x12345678 to 0x20 -> all outputs return to reset values and a later read of 0x20 does not return 0x12345678; WAIT_STATES=0 run -> latency 1.
REQ-038 Read 0x13 -> err=1, rdata=0 with MEM_RESPONDER_ALIGN_CHECK_EN defined; with it undefined, returns word 0x10 contents, err=0.
